cache_repair_unit: RTL

Executes one miss repair at a time on behalf of the MSHR. Accepts a repair request, fetches the missing line from memory, merges store data for store misses, and installs the line in the data cache. For loads, it also returns the missed word to the ROB. It then signals completion so the MSHR can retire the entry. It sits between the MSHR (upstream) and the memory bus plus the cache data/tag write port (downstream).

---
 rtl/cache_repair_unit_pkg.sv | 27 ++
 rtl/cache_repair_unit_line_buffer.sv | 48 ++++
 rtl/cache_repair_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/cache_repair_unit_pkg.sv
// Shared types and constants for the miss-repair engine.
package cache_repair_unit_pkg;

    localparam int CACHE_LINE_WORDS = 4;
    localparam int ROB_ENTRIES      = 32;
    localparam int ROB_IDX_MAX_W    = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } repair_state_e;

    typedef struct packed {
        logic [31:0]              addr;
        logic [31:0]              data;
        logic [ROB_IDX_MAX_W-1:0] rob_idx;
        logic                     is_store;
    } repair_req_t;

    function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned off_bits);
        return (addr >> off_bits) << off_bits;
    endfunction

endpackage

// File: rtl/cache_repair_unit_line_buffer.sv
// Line assembly buffer: collects response beats, merges store data, captures the load word.
module repair_line_buffer
    import cache_repair_unit_pkg::*;
#(
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [31:0]             wdata,
    input  logic                    merge_en,
    input  logic [IDX_W-1:0]        merge_idx,
    input  logic [31:0]             merge_data,
    output logic [32*LINE_WORDS-1:0] line_o,
    output logic                    last_o,
    output logic [31:0]             word_o
);

    logic [LINE_WORDS-1:0][31:0] line_q;
    logic [IDX_W-1:0]            beat_q;
    logic [31:0]                 word_q;
    logic                        hit;

    assign hit = (beat_q == merge_idx);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
            beat_q <= '0;
            word_q <= '0;
        end else if (clear) begin
            beat_q <= '0;
        end else if (wr_en) begin
            // store data replaces the fetched word at the miss offset
            line_q[beat_q] <= (merge_en && hit) ? merge_data : wdata;
            if (!merge_en && hit)
                word_q <= wdata;
            beat_q <= beat_q + IDX_W'(1);
        end
    end

    assign line_o = line_q;
    assign last_o = (beat_q == IDX_W'(LINE_WORDS - 1));
    assign word_o = word_q;

endmodule

// File: rtl/cache_repair_unit.sv
// Single-outstanding miss repair: fetch line, merge store, fill cache, write back load word.
module cache_repair_unit
    import cache_repair_unit_pkg::*;
#(
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    parameter int ROB_IDX_W  = $clog2(ROB_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     repair_req_i,
    input  logic [31:0]              repair_addr_i,
    input  logic [31:0]              repair_data_i,
    input  logic [ROB_IDX_W-1:0]     repair_rob_idx_i,
    input  logic                     repair_is_store_i,
    output logic                     repair_ack_o,
    output logic                     repair_complete_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     fill_valid_o,
    output logic [31:0]              fill_addr_o,
    output logic [32*LINE_WORDS-1:0] fill_data_o,
    output logic                     fill_dirty_o,
    input  logic                     fill_ready_i,
    output logic                     wb_valid_o,
    output logic [31:0]              wb_data_o,
    output logic [ROB_IDX_W-1:0]     wb_rob_idx_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF   = IDX_W + 2;

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_REQ  = REQ;
    localparam logic [2:0] S_RESP = RESP;
    localparam logic [2:0] S_FILL = FILL;
    localparam logic [2:0] S_DONE = DONE;

    logic [2:0]        state_q, state_d;
    repair_req_t       req_q;
    logic              abort_q;
    logic              accept, wr_en, last;
    logic [IDX_W-1:0]  merge_idx;
    logic [31:0]       word;
    logic [32*LINE_WORDS-1:0] line;

    // reset gates the ack so every output reads zero while rst_i is held
    assign repair_ack_o = (state_q == S_IDLE) && !flush_i && !rst_i;
    assign accept       = repair_req_i && repair_ack_o;
    assign wr_en        = (state_q == S_RESP) && mem_rvalid_i;
    assign merge_idx    = req_q.addr[OFF-1:2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ: begin
                if (mem_gnt_i)    state_d = S_RESP;
                else if (flush_i) state_d = S_DONE;
            end
            S_RESP: if (wr_en && last) state_d = (abort_q || flush_i) ? S_DONE : S_FILL;
            S_FILL: if (fill_ready_i) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            abort_q <= 1'b0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            // sticky until the FSM returns to idle; flush in DONE/IDLE lands on idle and drops
            abort_q <= (state_d != S_IDLE) && (abort_q || flush_i);
            if (accept) begin
                req_q.addr     <= repair_addr_i;
                req_q.data     <= repair_data_i;
                req_q.rob_idx  <= ROB_IDX_MAX_W'(repair_rob_idx_i);
                req_q.is_store <= repair_is_store_i;
            end
        end
    end

    repair_line_buffer #(.LINE_WORDS(LINE_WORDS)) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear      (accept),
        .wr_en      (wr_en),
        .wdata      (mem_rdata_i),
        .merge_en   (req_q.is_store),
        .merge_idx  (merge_idx),
        .merge_data (req_q.data),
        .line_o     (line),
        .last_o     (last),
        .word_o     (word)
    );

    assign mem_req_o         = (state_q == S_REQ);
    assign mem_addr_o        = line_base(req_q.addr, OFF);
    assign fill_valid_o      = (state_q == S_FILL);
    assign fill_addr_o       = line_base(req_q.addr, OFF);
    assign fill_data_o       = line;
    assign fill_dirty_o      = (state_q == S_FILL) && req_q.is_store;
    assign repair_complete_o = (state_q == S_DONE);
    assign wb_valid_o        = (state_q == S_DONE) && !req_q.is_store && !abort_q;
    assign wb_data_o         = word;
    assign wb_rob_idx_o      = req_q.rob_idx[ROB_IDX_W-1:0];

endmodule
